// File: rtl/iss_pkg.sv
// Shared issue-entry field layout, widths, and the held-entry record for the register-read stage.
package iss_pkg;
    localparam int IQLSQ_WIDTH = 137;
    localparam int PREG_BITS   = 6;
    localparam int NUM_PREGS   = 1 << PREG_BITS;
    localparam int DATA_WIDTH  = 32;

    localparam int PCA_HI      = 136;
    localparam int PCA_LO      = 105;
    localparam int READY_BIT   = 104;
    localparam int LINK_BIT    = 103;
    localparam int JUMPREG_BIT = 102;
    localparam int JUMP_BIT    = 101;
    localparam int BRANCH_BIT  = 100;
    localparam int MEMWR_BIT   = 99;
    localparam int MEMRD_BIT   = 98;
    localparam int IMMSRC_BIT  = 97;
    localparam int NEEDDST_BIT = 96;
    localparam int DEST_HI     = 95;
    localparam int DEST_LO     = 90;
    localparam int SRC2_HI     = 88;
    localparam int SRC2_LO     = 83;
    localparam int SRC1_HI     = 81;
    localparam int SRC1_LO     = 76;
    localparam int IMM_HI      = 75;
    localparam int IMM_LO      = 44;
    localparam int ALUCTL_HI   = 43;
    localparam int ALUCTL_LO   = 38;
    localparam int ROB_HI      = 37;
    localparam int ROB_LO      = 32;
    localparam int INSTR_HI    = 31;
    localparam int INSTR_LO    = 0;

    typedef struct packed {
        logic [IQLSQ_WIDTH-1:0] entry;
        logic [DATA_WIDTH-1:0]  opA;
        logic [DATA_WIDTH-1:0]  opB;
        logic                   mem;
    } held_t;

    // Refresh a waiting entry's register operands from the writeback ports; WB1 beats WB0.
    function automatic held_t snoop_held(
        input held_t                  h,
        input logic                   we0,
        input logic [PREG_BITS-1:0]   reg0,
        input logic [DATA_WIDTH-1:0]  data0,
        input logic                   we1,
        input logic [PREG_BITS-1:0]   reg1,
        input logic [DATA_WIDTH-1:0]  data1
    );
        held_t r;
        r = h;
        if (we1 && reg1 == h.entry[SRC1_HI:SRC1_LO])
            r.opA = data1;
        else if (we0 && reg0 == h.entry[SRC1_HI:SRC1_LO])
            r.opA = data0;
        if (!h.entry[IMMSRC_BIT]) begin
            if (we1 && reg1 == h.entry[SRC2_HI:SRC2_LO])
                r.opB = data1;
            else if (we0 && reg0 == h.entry[SRC2_HI:SRC2_LO])
                r.opB = data0;
        end
        return r;
    endfunction
endpackage

// File: rtl/reg_read_dispatch_if.sv
// Issue, writeback and downstream bus of the register-read stage.
interface reg_read_dispatch_if;
    import iss_pkg::*;

    logic [IQLSQ_WIDTH-1:0] ISS_data_IN;
    logic                   ISS_valid_IN;
    logic                   ISS_mem_IN;
    logic                   FREEZE_OUT;
    logic                   FLUSH_IN;
    logic                   WB0_we_IN;
    logic [PREG_BITS-1:0]   WB0_reg_IN;
    logic [DATA_WIDTH-1:0]  WB0_data_IN;
    logic                   WB1_we_IN;
    logic [PREG_BITS-1:0]   WB1_reg_IN;
    logic [DATA_WIDTH-1:0]  WB1_data_IN;
    logic                   EX_ready_IN;
    logic                   MEM_ready_IN;
    logic                   EX_valid_OUT;
    logic                   MEM_valid_OUT;
    logic [IQLSQ_WIDTH-1:0] OUT_entry;
    logic [DATA_WIDTH-1:0]  OUT_opA;
    logic [DATA_WIDTH-1:0]  OUT_opB;

    modport slave (
        input  ISS_data_IN, ISS_valid_IN, ISS_mem_IN, FLUSH_IN,
        input  WB0_we_IN, WB0_reg_IN, WB0_data_IN,
        input  WB1_we_IN, WB1_reg_IN, WB1_data_IN,
        input  EX_ready_IN, MEM_ready_IN,
        output FREEZE_OUT, EX_valid_OUT, MEM_valid_OUT,
        output OUT_entry, OUT_opA, OUT_opB
    );

    modport master (
        output ISS_data_IN, ISS_valid_IN, ISS_mem_IN, FLUSH_IN,
        output WB0_we_IN, WB0_reg_IN, WB0_data_IN,
        output WB1_we_IN, WB1_reg_IN, WB1_data_IN,
        output EX_ready_IN, MEM_ready_IN,
        input  FREEZE_OUT, EX_valid_OUT, MEM_valid_OUT,
        input  OUT_entry, OUT_opA, OUT_opB
    );
endinterface

// File: rtl/prf_2r2w.sv
// 64x32 physical register file: two combinational read ports with writeback bypass, two write ports.
module prf_2r2w
    import iss_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we0,
    input  logic [PREG_BITS-1:0]  i_waddr0,
    input  logic [DATA_WIDTH-1:0] i_wdata0,
    input  logic                  i_we1,
    input  logic [PREG_BITS-1:0]  i_waddr1,
    input  logic [DATA_WIDTH-1:0] i_wdata1,
    input  logic [PREG_BITS-1:0]  i_raddr_a,
    output logic [DATA_WIDTH-1:0] o_rdata_a,
    input  logic [PREG_BITS-1:0]  i_raddr_b,
    output logic [DATA_WIDTH-1:0] o_rdata_b
);
    logic [DATA_WIDTH-1:0] r_mem [NUM_PREGS];

    // WB1 is written last so it wins a same-address collision.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_PREGS; i++)
                r_mem[i] <= '0;
        end else begin
            if (i_we0)
                r_mem[i_waddr0] <= i_wdata0;
            if (i_we1)
                r_mem[i_waddr1] <= i_wdata1;
        end
    end

    always_comb begin
        o_rdata_a = r_mem[i_raddr_a];
        if (i_we1 && i_waddr1 == i_raddr_a)
            o_rdata_a = i_wdata1;
        else if (i_we0 && i_waddr0 == i_raddr_a)
            o_rdata_a = i_wdata0;

        o_rdata_b = r_mem[i_raddr_b];
        if (i_we1 && i_waddr1 == i_raddr_b)
            o_rdata_b = i_wdata1;
        else if (i_we0 && i_waddr0 == i_raddr_b)
            o_rdata_b = i_wdata0;
    end
endmodule

// File: rtl/reg_read_dispatch.sv
// Register-read stage with 1-entry skid buffer and EX/MEM routing.
// Optional perf counters enabled by defining RRD_PERF_CNT_EN.
module reg_read_dispatch
    import iss_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    reg_read_dispatch_if.slave   bus
`ifdef RRD_PERF_CNT_EN
    ,
    output logic [31:0]          perf_issued_OUT,
    output logic [31:0]          perf_stall_OUT
`endif
);
    // state | meaning
    // EMPTY | nothing held
    // ONE   | output register valid, skid empty
    // TWO   | output register and skid both valid, issue frozen
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t                r_state;
    held_t                 r_out;
    held_t                 r_skid;
    logic                  r_freeze;
    logic                  r_ex_v;
    logic                  r_mem_v;

    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;
    held_t                 w_new;
    held_t                 w_out_snp;
    held_t                 w_skid_snp;
    logic                  w_consume;

    prf_2r2w u_prf (
        .i_clk     (CLK),
        .i_rst     (RESET),
        .i_we0     (bus.WB0_we_IN),
        .i_waddr0  (bus.WB0_reg_IN),
        .i_wdata0  (bus.WB0_data_IN),
        .i_we1     (bus.WB1_we_IN),
        .i_waddr1  (bus.WB1_reg_IN),
        .i_wdata1  (bus.WB1_data_IN),
        .i_raddr_a (bus.ISS_data_IN[SRC1_HI:SRC1_LO]),
        .o_rdata_a (w_rd_a),
        .i_raddr_b (bus.ISS_data_IN[SRC2_HI:SRC2_LO]),
        .o_rdata_b (w_rd_b)
    );

    always_comb begin
        w_new.entry = bus.ISS_data_IN;
        w_new.opA   = w_rd_a;
        w_new.opB   = bus.ISS_data_IN[IMMSRC_BIT] ? bus.ISS_data_IN[IMM_HI:IMM_LO] : w_rd_b;
        w_new.mem   = bus.ISS_mem_IN;
    end

    assign w_out_snp  = snoop_held(r_out, bus.WB0_we_IN, bus.WB0_reg_IN, bus.WB0_data_IN,
                                   bus.WB1_we_IN, bus.WB1_reg_IN, bus.WB1_data_IN);
    assign w_skid_snp = snoop_held(r_skid, bus.WB0_we_IN, bus.WB0_reg_IN, bus.WB0_data_IN,
                                   bus.WB1_we_IN, bus.WB1_reg_IN, bus.WB1_data_IN);
    assign w_consume  = (r_state != EMPTY) && (r_out.mem ? bus.MEM_ready_IN : bus.EX_ready_IN);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= EMPTY;
            r_out    <= '0;
            r_skid   <= '0;
            r_freeze <= 1'b0;
            r_ex_v   <= 1'b0;
            r_mem_v  <= 1'b0;
        end else if (bus.FLUSH_IN) begin
            r_state  <= EMPTY;
            r_freeze <= 1'b0;
            r_ex_v   <= 1'b0;
            r_mem_v  <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (bus.ISS_valid_IN) begin
                        r_out   <= w_new;
                        r_state <= ONE;
                        r_ex_v  <= !w_new.mem;
                        r_mem_v <= w_new.mem;
                    end
                end
                ONE: begin
                    if (w_consume) begin
                        if (bus.ISS_valid_IN) begin
                            r_out   <= w_new;
                            r_ex_v  <= !w_new.mem;
                            r_mem_v <= w_new.mem;
                        end else begin
                            r_state <= EMPTY;
                            r_ex_v  <= 1'b0;
                            r_mem_v <= 1'b0;
                        end
                    end else begin
                        r_out <= w_out_snp;
                        if (bus.ISS_valid_IN) begin
                            r_skid   <= w_new;
                            r_state  <= TWO;
                            r_freeze <= 1'b1;
                        end
                    end
                end
                TWO: begin
                    // Any issue arriving here is a protocol violation and is dropped.
                    if (w_consume) begin
                        r_out    <= w_skid_snp;
                        r_state  <= ONE;
                        r_freeze <= 1'b0;
                        r_ex_v   <= !w_skid_snp.mem;
                        r_mem_v  <= w_skid_snp.mem;
                    end else begin
                        r_out  <= w_out_snp;
                        r_skid <= w_skid_snp;
                    end
                end
                default: begin
                    r_state  <= EMPTY;
                    r_freeze <= 1'b0;
                    r_ex_v   <= 1'b0;
                    r_mem_v  <= 1'b0;
                end
            endcase
        end
    end

    a_no_issue_in_two: assert property (@(posedge CLK) disable iff (RESET)
        !(r_state == TWO && bus.ISS_valid_IN && !bus.FLUSH_IN));

    assign bus.FREEZE_OUT    = r_freeze;
    assign bus.EX_valid_OUT  = r_ex_v;
    assign bus.MEM_valid_OUT = r_mem_v;
    assign bus.OUT_entry     = r_out.entry;
    assign bus.OUT_opA       = r_out.opA;
    assign bus.OUT_opB       = r_out.opB;

`ifdef RRD_PERF_CNT_EN
    logic [31:0] r_perf_issued;
    logic [31:0] r_perf_stall;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_perf_issued <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (w_consume && !bus.FLUSH_IN)
                r_perf_issued <= r_perf_issued + 32'd1;
            if (r_freeze)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_issued_OUT = r_perf_issued;
    assign perf_stall_OUT  = r_perf_stall;
`endif
endmodule
